// File: rtl/dec2_field_latch.sv
// decode2 input stage: captures one decode1 instruction per cycle, extracts disp/imm,
// and buffers through an output entry plus a skid entry so the stall back is registered.
module dec2_field_latch (
  input  logic         CLK,
  input  logic         reset,
  input  logic         dec1_valid,
  input  logic [103:0] inst_bytes,
  input  logic         has_prefix1,
  input  logic         has_prefix2,
  input  logic         has_prefix3,
  input  logic         has_op2,
  input  logic         has_modrm,
  input  logic         has_sib,
  input  logic         has_disp8,
  input  logic         has_disp32,
  input  logic         has_imm8,
  input  logic         has_imm16,
  input  logic         has_imm32,
  input  logic [3:0]   inst_size,
  input  logic [7:0]   opcode1_byte,
  input  logic [7:0]   opcode2_byte,
  input  logic [7:0]   modrm_byte,
  input  logic [7:0]   sib_byte,
  input  logic [7:0]   prefix2_byte,
  input  logic [31:0]  eip,
  input  logic         d3_stall,
  input  logic         d2_inv,
  output logic         dec2_stall,
  output logic         d2_valid,
  output logic [31:0]  d2_eip,
  output logic [31:0]  d2_next_eip,
  output logic [31:0]  d2_disp,
  output logic [31:0]  d2_imm,
  output logic [7:0]   d2_opcode1,
  output logic [7:0]   d2_opcode2,
  output logic [7:0]   d2_modrm,
  output logic [7:0]   d2_sib,
  output logic [7:0]   d2_prefix2,
  output logic [10:0]  d2_flags,
  output logic         d2_len_err
);

  typedef struct packed {
    logic [31:0] eip;
    logic [31:0] next_eip;
    logic [31:0] disp;
    logic [31:0] imm;
    logic [7:0]  opcode1;
    logic [7:0]  opcode2;
    logic [7:0]  modrm;
    logic [7:0]  sib;
    logic [7:0]  prefix2;
    logic [10:0] flags;
    logic        len_err;
  } entry_t;

  // Bytes 13..15 read as zero so offsets past b12 index safely.
  logic [7:0] win [16];
  for (genvar g = 0; g < 13; g++) begin : g_win
    assign win[g] = inst_bytes[g*8 +: 8];
  end
  assign win[13] = 8'h00;
  assign win[14] = 8'h00;
  assign win[15] = 8'h00;

  logic [3:0] pfx_cnt, disp_off, imm_off;
  logic [31:0] disp_val, imm_val;
  logic        disp_err, imm_err, size_zero;
  entry_t      in_entry;

  always_comb begin
    pfx_cnt   = 4'(has_prefix1) + 4'(has_prefix2) + 4'(has_prefix3);
    disp_off  = pfx_cnt + 4'd1 + 4'(has_op2) + 4'(has_modrm) + 4'(has_sib);
    imm_off   = disp_off + (has_disp32 ? 4'd4 : (has_disp8 ? 4'd1 : 4'd0));
    size_zero = (inst_size == 4'd0);

    disp_val = 32'h0;
    disp_err = 1'b0;
    if (has_disp32) begin
      disp_err = (disp_off > 4'd9);
      disp_val = {win[4'(disp_off + 4'd3)], win[4'(disp_off + 4'd2)],
                  win[4'(disp_off + 4'd1)], win[disp_off]};
    end else if (has_disp8) begin
      disp_err = (disp_off > 4'd12);
      disp_val = {{24{win[disp_off][7]}}, win[disp_off]};
    end

    imm_val = 32'h0;
    imm_err = 1'b0;
    if (has_imm32) begin
      imm_err = (imm_off > 4'd9);
      imm_val = {win[4'(imm_off + 4'd3)], win[4'(imm_off + 4'd2)],
                 win[4'(imm_off + 4'd1)], win[imm_off]};
    end else if (has_imm16) begin
      imm_err = (imm_off > 4'd11);
      imm_val = {16'h0, win[4'(imm_off + 4'd1)], win[imm_off]};
    end else if (has_imm8) begin
      imm_err = (imm_off > 4'd12);
      imm_val = {{24{win[imm_off][7]}}, win[imm_off]};
    end

    in_entry          = '0;
    in_entry.eip      = eip;
    in_entry.next_eip = eip + {28'h0, inst_size};
    in_entry.disp     = (disp_err || size_zero) ? 32'h0 : disp_val;
    in_entry.imm      = (imm_err || size_zero) ? 32'h0 : imm_val;
    in_entry.opcode1  = opcode1_byte;
    in_entry.opcode2  = opcode2_byte;
    in_entry.modrm    = modrm_byte;
    in_entry.sib      = sib_byte;
    in_entry.prefix2  = prefix2_byte;
    in_entry.flags    = {has_prefix1, has_prefix2, has_prefix3, has_op2, has_modrm, has_sib,
                         has_disp8, has_disp32, has_imm8, has_imm16, has_imm32};
    in_entry.len_err  = disp_err | imm_err | size_zero;
  end

  entry_t out_q, out_d, skd_q, skd_d;
  logic   out_v_q, out_v_d, skd_v_q, skd_v_d;
  logic   accept, consume;

  // dec2_stall is skd_v_q itself, so accept never coincides with a full skid.
  assign accept  = dec1_valid & ~skd_v_q & ~d2_inv;
  assign consume = out_v_q & ~d3_stall;

  always_comb begin
    out_d   = out_q;
    skd_d   = skd_q;
    out_v_d = out_v_q;
    skd_v_d = skd_v_q;
    if (d2_inv) begin
      out_v_d = 1'b0;
      skd_v_d = 1'b0;
    end else if (skd_v_q) begin
      if (consume) begin
        out_d   = skd_q;
        skd_v_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_v_q || consume) begin
        out_d   = in_entry;
        out_v_d = 1'b1;
      end else begin
        skd_d   = in_entry;
        skd_v_d = 1'b1;
      end
    end else if (consume) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_q   <= '0;
      skd_q   <= '0;
      out_v_q <= 1'b0;
      skd_v_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      skd_q   <= skd_d;
      out_v_q <= out_v_d;
      skd_v_q <= skd_v_d;
    end
  end

  assign dec2_stall  = skd_v_q;
  assign d2_valid    = out_v_q;
  assign d2_eip      = out_q.eip;
  assign d2_next_eip = out_q.next_eip;
  assign d2_disp     = out_q.disp;
  assign d2_imm      = out_q.imm;
  assign d2_opcode1  = out_q.opcode1;
  assign d2_opcode2  = out_q.opcode2;
  assign d2_modrm    = out_q.modrm;
  assign d2_sib      = out_q.sib;
  assign d2_prefix2  = out_q.prefix2;
  assign d2_flags    = out_q.flags;
  assign d2_len_err  = out_q.len_err;

endmodule
